// File: rtl/aes_input_interface.sv
// Byte-serial loader for the AES-128 key and plaintext, plus the start/done
// handshake that keeps the engine running until it reports completion.
module aes_input_interface (
    input  logic         clk,
    input  logic         rst_,
    input  logic [7:0]   din,
    input  logic [1:0]   cmd,
    input  logic         engine_done,
    output logic         engine_start,
    output logic [127:0] plain_out,
    output logic [127:0] key_out,
    output logic         ready
);

    localparam logic [1:0] CmdNop   = 2'b00;
    localparam logic [1:0] CmdKey   = 2'b01;
    localparam logic [1:0] CmdPlain = 2'b10;
    localparam logic [1:0] CmdStart = 2'b11;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e         state_q, state_d;
    logic           start_q, start_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   plain_q, plain_d;

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        key_d   = key_q;
        plain_d = plain_q;
        unique case (state_q)
            StIdle: begin
                case (cmd)
                    CmdKey:   key_d   = {key_q[119:0], din};
                    CmdPlain: plain_d = {plain_q[119:0], din};
                    CmdStart: begin
                        state_d = StBusy;
                        start_d = 1'b1;
                    end
                    CmdNop:   ;
                    default:  ;
                endcase
            end
            StBusy: begin
                // done is only honoured from BUSY, so the run always lasts at least one cycle
                if (engine_done) begin
                    state_d = StIdle;
                    start_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            key_q   <= '0;
            plain_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            key_q   <= key_d;
            plain_q <= plain_d;
        end
    end

    assign engine_start = start_q;
    assign key_out      = key_q;
    assign plain_out    = plain_q;
    assign ready        = (state_q == StIdle);

endmodule

// File: tb/tb_aes_input_interface.sv
// Self-checking bench for aes_input_interface: vector table, directed
// handshake/reset/overflow sequences, and a randomized run against a byte-queue model.
module tb_aes_input_interface;

    logic         clk = 1'b0;
    logic         rst_ = 1'b0;
    logic [7:0]   din = 8'h00;
    logic [1:0]   cmd = 2'b00;
    logic         engine_done = 1'b0;
    logic         engine_start;
    logic [127:0] plain_out;
    logic [127:0] key_out;
    logic         ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: keys/plaintexts are "the last 16 bytes loaded", zero-padded in front.
    logic [7:0] m_key[$];
    logic [7:0] m_plain[$];
    bit         m_busy = 1'b0;

    aes_input_interface dut (
        .clk          (clk),
        .rst_         (rst_),
        .din          (din),
        .cmd          (cmd),
        .engine_done  (engine_done),
        .engine_start (engine_start),
        .plain_out    (plain_out),
        .key_out      (key_out),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] din;
        logic       done;
        logic       exp_start;
        logic       exp_ready;
        logic [7:0] exp_key_lo;
        logic [7:0] exp_plain_lo;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [127:0] pack(input logic [7:0] q[$]);
        logic [127:0] v = '0;
        int n = q.size();
        for (int i = 0; i < n; i++) v[8*(n-1-i) +: 8] = q[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_key.delete();
        m_plain.delete();
        m_busy = 1'b0;
    endtask

    // Drive one cycle of inputs, let the DUT see one rising edge, update the model.
    task automatic step(input logic [1:0] c, input logic [7:0] d, input logic dn);
        cmd = c;
        din = d;
        engine_done = dn;
        @(posedge clk);
        if (!m_busy) begin
            if (c == 2'b01) begin
                m_key.push_back(d);
                if (m_key.size() > 16) void'(m_key.pop_front());
            end else if (c == 2'b10) begin
                m_plain.push_back(d);
                if (m_plain.size() > 16) void'(m_plain.pop_front());
            end else if (c == 2'b11) begin
                m_busy = 1'b1;
            end
        end else if (dn) begin
            m_busy = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [127:0] key_snap, plain_snap;

        vecs[0]  = '{2'd0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
        vecs[1]  = '{2'd1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00};
        vecs[2]  = '{2'd2, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C};
        vecs[3]  = '{2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C};
        vecs[4]  = '{2'd3, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C};
        vecs[5]  = '{2'd1, 8'h11, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C};
        vecs[6]  = '{2'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C};
        vecs[7]  = '{2'd1, 8'h77, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C};
        vecs[8]  = '{2'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C};
        vecs[9]  = '{2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C};
        vecs[10] = '{2'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C};
        vecs[11] = '{2'd2, 8'h99, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C};

        // Reset state
        #12;
        chk("reset_key", key_out, 128'h0);
        chk("reset_plain", plain_out, 128'h0);
        chk("reset_start", {127'h0, engine_start}, 128'h0);
        chk("reset_ready", {127'h0, ready}, 128'h1);
        rst_ = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].cmd, vecs[i].din, vecs[i].done);
            chk($sformatf("vec%0d_start", i), {127'h0, engine_start}, {127'h0, vecs[i].exp_start});
            chk($sformatf("vec%0d_ready", i), {127'h0, ready}, {127'h0, vecs[i].exp_ready});
            chk($sformatf("vec%0d_key_lo", i), {120'h0, key_out[7:0]}, {120'h0, vecs[i].exp_key_lo});
            chk($sformatf("vec%0d_plain_lo", i), {120'h0, plain_out[7:0]},
                {120'h0, vecs[i].exp_plain_lo});
        end

        // Key load 00..0F
        for (int i = 0; i < 16; i++) step(2'b01, 8'(i), 1'b0);
        chk("key_load", key_out, 128'h000102030405060708090a0b0c0d0e0f);
        // Plain load 00,11..FF
        for (int i = 0; i < 16; i++) step(2'b10, 8'(i * 8'h11), 1'b0);
        chk("plain_load", plain_out, 128'h00112233445566778899aabbccddeeff);
        chk("key_after_plain", key_out, 128'h000102030405060708090a0b0c0d0e0f);

        // Start handshake with busy lockout
        step(2'b11, 8'h00, 1'b0);
        chk("hs_start", {127'h0, engine_start}, 128'h1);
        chk("hs_ready", {127'h0, ready}, 128'h0);
        step(2'b01, 8'hAA, 1'b0);
        step(2'b10, 8'hBB, 1'b0);
        step(2'b11, 8'h00, 1'b0);
        step(2'b00, 8'h00, 1'b0);
        step(2'b01, 8'hAA, 1'b0);
        chk("busy_start_held", {127'h0, engine_start}, 128'h1);
        chk("busy_key", key_out, 128'h000102030405060708090a0b0c0d0e0f);
        chk("busy_plain", plain_out, 128'h00112233445566778899aabbccddeeff);
        step(2'b00, 8'h00, 1'b1);
        chk("done_start", {127'h0, engine_start}, 128'h0);
        chk("done_ready", {127'h0, ready}, 128'h1);
        // Back-to-back restart without reload
        step(2'b11, 8'h00, 1'b0);
        chk("b2b_start", {127'h0, engine_start}, 128'h1);
        chk("b2b_key", key_out, 128'h000102030405060708090a0b0c0d0e0f);

        // Asynchronous reset while busy
        #2;
        rst_ = 1'b0;
        #1;
        chk("mid_rst_start", {127'h0, engine_start}, 128'h0);
        chk("mid_rst_key", key_out, 128'h0);
        chk("mid_rst_plain", plain_out, 128'h0);
        chk("mid_rst_ready", {127'h0, ready}, 128'h1);
        rst_ = 1'b1;
        model_reset();

        // Overflow with NOPs interleaved
        for (int i = 0; i < 17; i++) begin
            step(2'b01, 8'(i), 1'b0);
            if (i % 4 == 0) step(2'b00, 8'hEE, 1'b0);
        end
        chk("overflow_key", key_out, 128'h0102030405060708090a0b0c0d0e0f10);
        chk("overflow_plain", plain_out, 128'h0);

        // Randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            step(2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 3) == 0));
            chk("rnd_key", key_out, pack(m_key));
            chk("rnd_plain", plain_out, pack(m_plain));
            chk("rnd_start", {127'h0, engine_start}, {127'h0, m_busy});
            chk("rnd_ready", {127'h0, ready}, {127'h0, !m_busy});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_input_interface.md
Name: aes_input_interface

Overview:
Byte-serial front end of the AES-128 engine. It collects a 128-bit key and a 128-bit plaintext one byte per clock under a 2-bit command, and presents both as parallel words. On a start command it raises engine_start to the key generator and round transformer and holds it until the engine reports done. A ready flag tells the host when commands are accepted.

Parameters:
None (block width fixed: 8-bit din, 128-bit key/plaintext, 16 bytes each).

Ports:
clk  input  1  system clock, all state on rising edge
rst_  input  1  asynchronous active-low reset
din  input  8  data byte for load commands
cmd  input  2  command: 00 NOP, 01 LOAD_KEY, 10 LOAD_PLAIN, 11 START
engine_done  input  1  completion level from round transformer (may be combinational from engine_start)
engine_start  output  1  run request to key generator, level
plain_out  output  128  assembled plaintext register
key_out  output  128  assembled key register
ready  output  1  high when commands are accepted

Behaviour:
- Reset (rst_=0, async): key_out=0, plain_out=0, engine_start=0, state=IDLE, ready=1.
- Two states: IDLE, BUSY. ready = (state==IDLE), combinational from state.
- IDLE, cmd=01: key_out <= {key_out[119:0], din}. First byte loaded ends in bits [127:120] after 16 loads.
- IDLE, cmd=10: plain_out <= {plain_out[119:0], din}, same ordering.
- No byte counter; more than 16 loads keep shifting (oldest byte drops out of MSB). Fewer than 16 leaves earlier contents in upper bytes.
- IDLE, cmd=00: hold all registers.
- IDLE, cmd=11: next edge engine_start<=1, state<=BUSY. key_out/plain_out unchanged. din ignored.
- BUSY: all cmd values ignored; key_out/plain_out frozen; engine_start held 1.
- BUSY, engine_done=1 sampled on a rising edge: engine_start<=0, state<=IDLE (ready=1 next cycle). Minimum BUSY duration one cycle, even if engine_done is already high when START is registered.
- engine_done high while IDLE: ignored.
- Reset mid-operation (any state): immediate return to reset values; engine_start drops asynchronously.
- Back-to-back: a START issued on the first IDLE cycle after completion is accepted normally; registers retain previous key/plaintext, so re-encryption without reload is allowed.
- All outputs registered except ready (decoded from state register only; no combinational path from inputs to outputs).

Test Plan:
- Reset: assert rst_=0 mid-stream with engine_start=1 -> engine_start, key_out, plain_out drop to 0 immediately, ready=1.
- Key load: cmd=01 with din=00,01,...,0F on 16 cycles -> key_out=000102030405060708090a0b0c0d0e0f, plain_out unchanged.
- Plain load: cmd=10 with din=00,11,22,...,FF -> plain_out=00112233445566778899aabbccddeeff; with attached engine, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Start handshake: cmd=11 -> next cycle engine_start=1, ready=0; hold engine_done=0 for 5 cycles then 1 -> engine_start=0 and ready=1 one edge later.
- Busy lockout: during BUSY drive cmd=01 din=AA and cmd=10 din=BB -> key_out/plain_out unchanged, second cmd=11 has no effect.
- Overflow/NOP: 17 LOAD_KEY bytes 00..10 -> key_out=0102030405060708090a0b0c0d0e0f10; cmd=00 cycles interleaved change nothing.
